// File: rtl/ram_rd_arb_2to1.sv
// ram_rd_arb_2to1: round-robin 2:1 sharing of a RAM read port with in-order tag routing of responses
module ram_rd_arb_2to1 #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = $clog2(MAX_OUTST) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src0_rd_req_val,
  input  logic [ADDR_W-1:0] src0_rd_req_addr,
  output logic              src0_rd_req_rdy,
  output logic              src0_rd_resp_val,
  output logic [DATA_W-1:0] src0_rd_resp_data,
  input  logic              src0_rd_resp_rdy,
  input  logic              src1_rd_req_val,
  input  logic [ADDR_W-1:0] src1_rd_req_addr,
  output logic              src1_rd_req_rdy,
  output logic              src1_rd_resp_val,
  output logic [DATA_W-1:0] src1_rd_resp_data,
  input  logic              src1_rd_resp_rdy,
  output logic              ram_rd_req_en,
  output logic [ADDR_W-1:0] ram_rd_req_addr,
  input  logic              ram_rd_req_rdy,
  input  logic              ram_rd_resp_val,
  input  logic [DATA_W-1:0] ram_rd_resp_data,
  output logic              ram_rd_resp_rdy,
  output logic [CNT_W-1:0]  outst_cnt,
  output logic              err_orphan_resp
);
  localparam int PTR_W = $clog2(MAX_OUTST);
  logic prio, win, full, busy, head, accept, hs;
  logic [MAX_OUTST-1:0] tags;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  always_comb begin
    win = (src0_rd_req_val & src1_rd_req_val) ? prio : src1_rd_req_val;
    full = outst_cnt == CNT_W'(MAX_OUTST);
    busy = outst_cnt != '0;
    head = tags[rd_ptr];
    ram_rd_req_en = (src0_rd_req_val | src1_rd_req_val) & !full;
    ram_rd_req_addr = win ? src1_rd_req_addr : src0_rd_req_addr;
    accept = ram_rd_req_en & ram_rd_req_rdy;
    src0_rd_req_rdy = accept & !win;
    src1_rd_req_rdy = accept & win;
    src0_rd_resp_val = ram_rd_resp_val & busy & !head;
    src1_rd_resp_val = ram_rd_resp_val & busy & head;
    src0_rd_resp_data = ram_rd_resp_data;
    src1_rd_resp_data = ram_rd_resp_data;
    ram_rd_resp_rdy = busy & (head ? src1_rd_resp_rdy : src0_rd_resp_rdy);
    hs = ram_rd_resp_val & ram_rd_resp_rdy;
  end
  // tags is the in-order owner FIFO; outst_cnt doubles as its occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio <= 1'b0;
      tags <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      outst_cnt <= '0;
      err_orphan_resp <= 1'b0;
    end else begin
      if (accept) begin
        tags[wr_ptr] <= win;
        wr_ptr <= wr_ptr + PTR_W'(1);
        prio <= ~win;
      end
      if (hs) rd_ptr <= rd_ptr + PTR_W'(1);
      outst_cnt <= outst_cnt + CNT_W'(accept) - CNT_W'(hs);
      if (ram_rd_resp_val & !busy) err_orphan_resp <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ram_rd_arb_2to1.sv
// tb_ram_rd_arb_2to1: scoreboard bench with a behavioural RAM and owner-queue reference model
module tb_ram_rd_arb_2to1;
  localparam int DATA_W = 32, DEPTH = 8, ADDR_W = 3, MAX_OUTST = 4, CNT_W = 3;
  logic clk = 0, rst = 0;
  logic v0 = 0, v1 = 0, rr0 = 1, rr1 = 1;
  logic [ADDR_W-1:0] a0 = '0, a1 = '0;
  logic rq0, rq1, rv0, rv1, ram_en, ram_resp_rdy, err;
  logic [DATA_W-1:0] rd0, rd1;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_req_rdy = 1, ram_resp_val = 0;
  logic [DATA_W-1:0] ram_resp_data = '0;
  logic [CNT_W-1:0] outst_cnt;
  int n_chk = 0, n_err = 0, got0 = 0, got1 = 0;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q [$], exp0 [$], exp1 [$];
  logic owners [$], dut_grants [$], resp_order [$];
  logic m_prio = 0, m_full = 0, m_err = 0, gate = 1, force_orphan = 0, mon_en = 0;
  logic mh;
  logic [DATA_W-1:0] md;

  always #5 clk = ~clk;

  ram_rd_arb_2to1 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst),
    .src0_rd_req_val(v0), .src0_rd_req_addr(a0), .src0_rd_req_rdy(rq0),
    .src0_rd_resp_val(rv0), .src0_rd_resp_data(rd0), .src0_rd_resp_rdy(rr0),
    .src1_rd_req_val(v1), .src1_rd_req_addr(a1), .src1_rd_req_rdy(rq1),
    .src1_rd_resp_val(rv1), .src1_rd_resp_data(rd1), .src1_rd_resp_rdy(rr1),
    .ram_rd_req_en(ram_en), .ram_rd_req_addr(ram_addr), .ram_rd_req_rdy(ram_req_rdy),
    .ram_rd_resp_val(ram_resp_val), .ram_rd_resp_data(ram_resp_data), .ram_rd_resp_rdy(ram_resp_rdy),
    .outst_cnt(outst_cnt), .err_orphan_resp(err)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic drive_ram();
    ram_resp_val = force_orphan | (gate & (ram_q.size() != 0));
    ram_resp_data = force_orphan ? DATA_W'($urandom) : (ram_q.size() != 0 ? ram_q[0] : '0);
  endtask

  // One clock: check arbitration at the falling edge, then advance RAM and model past the rising edge.
  task automatic cyc();
    logic ev, w, acc_dut, hs;
    logic [ADDR_W-1:0] a, wa;
    drive_ram();
    @(negedge clk);
    ev = (v0 | v1) & !m_full;
    w = (v0 & v1) ? m_prio : v1;
    wa = w ? a1 : a0;
    chk("ram_rd_req_en", ram_en, ev);
    if (ev) chk("ram_rd_req_addr", ram_addr, wa);
    chk("src0_rd_req_rdy", rq0, ev & ram_req_rdy & !w);
    chk("src1_rd_req_rdy", rq1, ev & ram_req_rdy & w);
    acc_dut = ram_en & ram_req_rdy;
    a = ram_addr;
    if (acc_dut) dut_grants.push_back(rq1);
    hs = ram_resp_val & ram_resp_rdy;
    @(posedge clk);
    #1;
    if (hs && !force_orphan && ram_q.size() != 0) void'(ram_q.pop_front());
    if (acc_dut) ram_q.push_back(mem[a]);
    if (ev & ram_req_rdy) begin
      owners.push_back(w);
      if (w) exp1.push_back(mem[wa]);
      else exp0.push_back(mem[wa]);
      m_prio = !w;
    end
    m_full = owners.size() == MAX_OUTST;
    drive_ram();
  endtask

  always @(negedge clk) begin
    if (!rst) m_err = 0;
    else if (mon_en) begin
      chk("outst_cnt", 64'(outst_cnt), 64'(owners.size()));
      chk("err_orphan_resp", err, m_err);
      if (owners.size() == 0) begin
        chk("idle_resp_val0", rv0, 1'b0);
        chk("idle_resp_val1", rv1, 1'b0);
        chk("idle_ram_resp_rdy", ram_resp_rdy, 1'b0);
        if (ram_resp_val) m_err = 1;
      end else begin
        mh = owners[0];
        chk("resp_val0", rv0, ram_resp_val & !mh);
        chk("resp_val1", rv1, ram_resp_val & mh);
        chk("ram_rd_resp_rdy", ram_resp_rdy, mh ? rr1 : rr0);
        if (ram_resp_val & (mh ? rr1 : rr0)) begin
          md = mh ? exp1.pop_front() : exp0.pop_front();
          chk("resp_data", mh ? rd1 : rd0, md);
          void'(owners.pop_front());
          resp_order.push_back(rv1);
          if (mh) got1++;
          else got0++;
        end
      end
    end
  end

  task automatic do_reset();
    mon_en = 0;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    m_prio = 0;
    m_full = 0;
    mon_en = 1;
  endtask

  initial begin
    int b0, b1;
    logic p;
    logic [3:0] g;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_outst_cnt", outst_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_req_rdy0", rq0, 0);
    chk("rst_req_rdy1", rq1, 0);
    chk("rst_resp_val0", rv0, 0);
    chk("rst_resp_val1", rv1, 0);
    chk("rst_ram_req_en", ram_en, 0);
    chk("rst_ram_resp_rdy", ram_resp_rdy, 0);
    @(posedge clk);
    #1;
    rst = 1;
    mon_en = 1;
    // single client, back-to-back
    v0 = 1;
    a0 = 3; cyc();
    a0 = 5; cyc();
    a0 = 7; cyc();
    v0 = 0;
    chk("single_grants", dut_grants.size(), 3);
    repeat (4) cyc();
    chk("single_got0", got0, 3);
    chk("single_got1", got1, 0);
    chk("single_cnt", outst_cnt, 0);
    // contention from reset: alternate starting with src0
    do_reset();
    dut_grants.delete();
    resp_order.delete();
    v0 = 1; v1 = 1; a0 = 1; a1 = 2;
    repeat (4) cyc();
    v0 = 0; v1 = 0;
    repeat (6) cyc();
    for (int i = 0; i < 4; i++) g[i] = (i < dut_grants.size()) ? dut_grants[i] : 1'bx;
    chk("contend_grants", g, 4'b1010);
    for (int i = 0; i < 4; i++) g[i] = (i < resp_order.size()) ? resp_order[i] : 1'bx;
    chk("contend_resp_order", g, 4'b1010);
    // outstanding limit with src1 stalling its responses
    dut_grants.delete();
    rr1 = 0; v1 = 1;
    repeat (6) begin
      a1 = ADDR_W'($urandom);
      cyc();
    end
    chk("limit_grants", dut_grants.size(), 4);
    #1;
    chk("limit_cnt", outst_cnt, 4);
    chk("limit_rdy1", rq1, 0);
    rr1 = 1;
    #1;
    chk("limit_no_bypass", rq1, 0);
    cyc();
    rr1 = 0;
    #1;
    chk("limit_slot_reuse", rq1, 1);
    cyc();
    chk("limit_grants_after", dut_grants.size(), 5);
    rr1 = 1; v1 = 0;
    repeat (8) cyc();
    chk("limit_drain_cnt", outst_cnt, 0);
    // head-of-line blocking
    b0 = got0; b1 = got1;
    rr0 = 0;
    v0 = 1; a0 = 0; cyc();
    v0 = 0; v1 = 1; a1 = 1; cyc();
    v1 = 0;
    repeat (5) cyc();
    chk("hol_blocked0", got0, b0);
    chk("hol_blocked1", got1, b1);
    rr0 = 1;
    repeat (4) cyc();
    chk("hol_release0", got0, b0 + 1);
    chk("hol_release1", got1, b1 + 1);
    // RAM request backpressure keeps priority
    p = m_prio;
    dut_grants.delete();
    ram_req_rdy = 0; v0 = 1; v1 = 1; a0 = 4; a1 = 6;
    repeat (3) cyc();
    chk("bp_no_accept", dut_grants.size(), 0);
    ram_req_rdy = 1;
    cyc();
    chk("bp_one_accept", dut_grants.size(), 1);
    chk("bp_first_winner", dut_grants.size() > 0 ? dut_grants[0] : 1'bx, p);
    v0 = 0; v1 = 0;
    repeat (6) cyc();
    // orphan response
    force_orphan = 1;
    drive_ram();
    #1;
    chk("orphan_resp_rdy", ram_resp_rdy, 0);
    chk("orphan_val0", rv0, 0);
    chk("orphan_val1", rv1, 0);
    chk("orphan_err_pre", err, 0);
    cyc();
    force_orphan = 0;
    drive_ram();
    #1;
    chk("orphan_err_set", err, 1);
    cyc();
    #1;
    chk("orphan_err_held", err, 1);
    rst = 0;
    #1;
    chk("orphan_async_clear", err, 0);
    @(posedge clk);
    #1;
    rst = 1;
    m_prio = 0;
    m_full = 0;
    // randomized traffic
    repeat (400) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      a0 = ADDR_W'($urandom); a1 = ADDR_W'($urandom);
      rr0 = ($urandom % 4) != 0; rr1 = ($urandom % 4) != 0;
      ram_req_rdy = ($urandom % 4) != 0;
      gate = ($urandom % 4) != 0;
      cyc();
    end
    v0 = 0; v1 = 0; rr0 = 1; rr1 = 1; ram_req_rdy = 1; gate = 1;
    repeat (20) cyc();
    chk("final_cnt", outst_cnt, 0);
    chk("final_exp0_left", exp0.size(), 0);
    chk("final_exp1_left", exp1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
